form_wave_mc: RTL and testbench

// - Parametrised successor to the DDS waveform former. Converts a DDS phase word into an
//   OUT_W-bit unsigned waveform: saw, reverse saw, triangle, square or pulse.
// - Adds glitch-free config changes applied only at phase wrap, a two-stage pipeline with valid,
//   a wrap sync pulse and period measurement. Sits between the DDS accumulator and the DAC.

---
 rtl/form_wave_mc.sv | 176 +++++++++++++++++
 tb/tb_form_wave_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/form_wave_mc.sv
// form_wave_mc: DDS phase word to OUT_W-bit waveform (saw, reverse saw, triangle,
// square, pulse). Config changes take effect only at phase wrap so every period is
// drawn with one shape. Two-stage pipeline: stage 1 shapes, stage 2 scales/registers.
// Optional feature macro: FW_AMP_EN (amplitude scaling in stage 2).
module form_wave_mc #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16,
  parameter int PW_W    = 8,
  parameter int PER_W   = 24
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_valid,
  input  logic [2:0]         form_req,
  input  logic [PW_W-1:0]    pw_req,
  input  logic [OUT_W-1:0]   amp_req,
  input  logic               cfg_load,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               sync_out,
  output logic [PER_W-1:0]   period_len,
  output logic               cfg_busy
);

  localparam logic [PW_W-1:0] PW_HALF = {1'b1, {(PW_W-1){1'b0}}};

  // Active and pending configuration
  logic [2:0]         form_q, pend_form_q;
  logic [PW_W-1:0]    pw_q, pend_pw_q;
  logic               busy_q;
  logic [PHASE_W-1:0] last_q;
  logic [PER_W-1:0]   cnt_q;

  // Stage 1 registers
  logic               s1_valid_q, s1_sync_q;
  logic [OUT_W-1:0]   s1_shape_q;
  logic [PER_W-1:0]   s1_per_q;

  // Stage 2 registers
  logic [OUT_W-1:0]   wave_q;
  logic               wave_valid_q, sync_q;
  logic [PER_W-1:0]   period_q;

  // Combinational next-state signals
  logic               wrap_d, apply_d;
  logic [2:0]         form_d;
  logic [PW_W-1:0]    pw_d;
  logic [OUT_W-1:0]   p_d, t_d, shape_d, scaled_d;
  logic [PW_W-1:0]    q_d;
  logic [PER_W-1:0]   cnt_inc_d;

  // A wrap is a valid phase that went backwards; pending config is used for that very sample.
  always_comb begin
    wrap_d    = phase_valid && (phase_in < last_q);
    apply_d   = wrap_d && busy_q;
    form_d    = apply_d ? pend_form_q : form_q;
    pw_d      = apply_d ? pend_pw_q : pw_q;
    p_d       = phase_in[PHASE_W-1 -: OUT_W];
    q_d       = phase_in[PHASE_W-1 -: PW_W];
    t_d       = {p_d[OUT_W-2:0], 1'b0};
    cnt_inc_d = (cnt_q == {PER_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Shape selection from the configuration effective for this sample
  always_comb begin
    shape_d = '0;
    case (form_d)
      3'd0:    shape_d = p_d;
      3'd1:    shape_d = ~p_d;
      3'd2:    shape_d = p_d[OUT_W-1] ? ~t_d : t_d;
      3'd3:    shape_d = p_d[OUT_W-1] ? {OUT_W{1'b1}} : '0;
      3'd4:    shape_d = (q_d <= pw_d) ? {OUT_W{1'b1}} : '0;
      default: shape_d = '0;
    endcase
  end

`ifdef FW_AMP_EN
  logic [OUT_W-1:0] amp_q, pend_amp_q, s1_amp_q, amp_d, unused_prod_lo;

  // Amplitude follows the same pending/apply path as form and pulse width
  always_comb begin
    amp_d = apply_d ? pend_amp_q : amp_q;
    {scaled_d, unused_prod_lo} = (2*OUT_W)'(s1_shape_q) * (2*OUT_W)'(s1_amp_q);
  end

  // Amplitude state, carried through stage 1 alongside the shape
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      amp_q      <= {OUT_W{1'b1}};
      pend_amp_q <= '0;
      s1_amp_q   <= '0;
    end else begin
      if (apply_d)     amp_q      <= pend_amp_q;
      if (cfg_load)    pend_amp_q <= amp_req;
      if (phase_valid) s1_amp_q   <= amp_d;
    end
  end
`else
  logic unused_amp;

  // Without scaling stage 2 just re-registers the shape
  always_comb begin
    scaled_d   = s1_shape_q;
    unused_amp = ^amp_req;
  end
`endif

  // Config bookkeeping, wrap detection state and period counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      form_q      <= '0;
      pw_q        <= PW_HALF;
      pend_form_q <= '0;
      pend_pw_q   <= '0;
      busy_q      <= 1'b0;
      last_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (apply_d) begin
        form_q <= pend_form_q;
        pw_q   <= pend_pw_q;
      end
      if (cfg_load) begin
        pend_form_q <= form_req;
        pend_pw_q   <= pw_req;
        busy_q      <= 1'b1;
      end else if (apply_d) begin
        busy_q <= 1'b0;
      end
      if (phase_valid) begin
        last_q <= phase_in;
        cnt_q  <= wrap_d ? '0 : cnt_inc_d;
      end
    end
  end

  // Stage 1: capture shape, sync flag and finished period length
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_shape_q <= '0;
      s1_per_q   <= '0;
    end else begin
      s1_valid_q <= phase_valid;
      if (phase_valid) begin
        s1_sync_q  <= wrap_d;
        s1_shape_q <= shape_d;
        s1_per_q   <= cnt_inc_d;
      end
    end
  end

  // Stage 2: outputs; wave_out and period_len hold across bubbles
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wave_q       <= '0;
      wave_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      period_q     <= '0;
    end else begin
      wave_valid_q <= s1_valid_q;
      sync_q       <= s1_valid_q && s1_sync_q;
      if (s1_valid_q)              wave_q   <= scaled_d;
      if (s1_valid_q && s1_sync_q) period_q <= s1_per_q;
    end
  end

  assign wave_out   = wave_q;
  assign wave_valid = wave_valid_q;
  assign sync_out   = sync_q;
  assign period_len = period_q;
  assign cfg_busy   = busy_q;

endmodule

// File: tb/tb_form_wave_mc.sv
// Testbench for form_wave_mc: directed spec cases plus random stimulus checked
// against a per-sample behavioural model. PER_W is reduced so saturation is reachable.
module tb_form_wave_mc;
  localparam int PER_W   = 5;
  localparam int PER_MAX = 31;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] phase_in = '0;
  logic        phase_valid = 1'b0;
  logic [2:0]  form_req = '0;
  logic [7:0]  pw_req = '0;
  logic [15:0] amp_req = '0;
  logic        cfg_load = 1'b0;
  logic [15:0] wave_out;
  logic        wave_valid, sync_out, cfg_busy;
  logic [PER_W-1:0] period_len;

  form_wave_mc #(.PHASE_W(32), .OUT_W(16), .PW_W(8), .PER_W(PER_W)) dut (
    .CLK(CLK), .RESET(RESET), .phase_in(phase_in), .phase_valid(phase_valid),
    .form_req(form_req), .pw_req(pw_req), .amp_req(amp_req), .cfg_load(cfg_load),
    .wave_out(wave_out), .wave_valid(wave_valid), .sync_out(sync_out),
    .period_len(period_len), .cfg_busy(cfg_busy)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  int          m_form, m_pw, m_amp, m_pform, m_ppw, m_pamp, m_cnt;
  logic        m_busy;
  logic [31:0] m_last;
  int          m_wave, m_period;
  logic        pv_valid, pv_sync;
  int          pv_wave, pv_per;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_shape(input int f, input logic [31:0] ph, input int pw);
    int p;
    p = int'(ph >> 16);
    case (f)
      0: return p;
      1: return 65535 - p;
      2: return (p < 32768) ? 2 * p : 65535 - (2 * p - 65536);
      3: return (p >= 32768) ? 65535 : 0;
      4: return (int'(ph >> 24) <= pw) ? 65535 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_scale(input int s, input int a);
`ifdef FW_AMP_EN
    longint prod;
    prod = longint'(s) * longint'(a);
    return int'(prod >> 16);
`else
    return s + 0 * a;
`endif
  endfunction

  task automatic model_reset();
    m_form = 0; m_pw = 128; m_amp = 65535;
    m_pform = 0; m_ppw = 0; m_pamp = 0; m_busy = 1'b0;
    m_last = '0; m_cnt = 0; m_wave = 0; m_period = 0;
    pv_valid = 1'b0; pv_sync = 1'b0; pv_wave = 0; pv_per = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    check("rst_wave", 32'(wave_out), 32'd0);
    check("rst_valid", 32'(wave_valid), 32'd0);
    check("rst_sync", 32'(sync_out), 32'd0);
    check("rst_period", 32'(period_len), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, then check outputs after the edge
  task automatic step(input logic [31:0] ph, input logic v, input logic ld,
                      input int f, input int pw, input int amp);
    logic wrap;
    logic nv, ns;
    int   nw, np;
    phase_in = ph; phase_valid = v; cfg_load = ld;
    form_req = 3'(f); pw_req = 8'(pw); amp_req = 16'(amp);
    nv = v; ns = 1'b0; nw = 0; np = 0;
    if (v) begin
      wrap = (ph < m_last);
      if (wrap && m_busy) begin
        m_form = m_pform; m_pw = m_ppw; m_amp = m_pamp; m_busy = 1'b0;
      end
      nw = ref_scale(ref_shape(m_form, ph, m_pw), m_amp);
      m_last = ph;
      if (wrap) begin
        np = (m_cnt + 1 > PER_MAX) ? PER_MAX : m_cnt + 1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1 > PER_MAX) ? PER_MAX : m_cnt + 1;
      end
      ns = wrap;
    end
    if (ld) begin
      m_pform = f; m_ppw = pw; m_pamp = amp; m_busy = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (pv_valid) m_wave = pv_wave;
    if (pv_valid && pv_sync) m_period = pv_per;
    check("wave_valid", 32'(wave_valid), 32'(pv_valid));
    check("wave_out", 32'(wave_out), 32'(m_wave));
    check("sync_out", 32'(sync_out), 32'(pv_valid && pv_sync));
    check("period_len", 32'(period_len), 32'(m_period));
    check("cfg_busy", 32'(cfg_busy), 32'(m_busy));
    $display("step ph=%08h v=%0d ld=%0d form=%0d -> wave=%04h vld=%0d sync=%0d per=%0d busy=%0d",
             ph, v, ld, f, wave_out, wave_valid, sync_out, period_len, cfg_busy);
    pv_valid = nv; pv_sync = ns; pv_wave = nw; pv_per = np;
  endtask

  initial begin
    logic [31:0] ph;
    logic        v, ld;
    model_reset();
    #2;
    do_reset();

    // Form 0 saw, latency 2
    step(32'h4000_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'h0, 0, 0, 0, 0, 16'hFFFF);
    check("saw_4000", 32'(wave_out), 32'h4000);
    check("saw_valid", 32'(wave_valid), 32'd1);

    // Triangle via cfg_load + wrap
    step(32'h5000_0000, 1, 1, 2, 0, 16'hFFFF);
    step(32'h1000_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'hC000_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'h4000_0000, 1, 0, 0, 0, 16'hFFFF);
    check("tri_c000", 32'(wave_out), 32'h7FFF);
    step(32'h0, 0, 0, 0, 0, 16'hFFFF);
    check("tri_4000", 32'(wave_out), 32'h8000);

    // Pulse, pw=0x3F
    step(32'h5000_0000, 1, 1, 4, 8'h3F, 16'hFFFF);
    step(32'h3F00_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'h4000_0000, 1, 0, 0, 0, 16'hFFFF);
    check("pulse_3f", 32'(wave_out), 32'hFFFF);
    step(32'h0, 0, 0, 0, 0, 16'hFFFF);
    check("pulse_40", 32'(wave_out), 32'h0000);

    // Config pending until wrap, then reset
    step(32'h5000_0000, 1, 1, 0, 0, 16'hFFFF);
    step(32'h0000_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'h5000_0000, 1, 1, 1, 0, 16'hFFFF);
    check("busy_pending", 32'(cfg_busy), 32'd1);
    step(32'hF000_0000, 1, 0, 0, 0, 16'hFFFF);
    step(32'h1000_0000, 1, 0, 0, 0, 16'hFFFF);
    check("pre_wrap_saw", 32'(wave_out), 32'hF000);
    step(32'h0, 0, 0, 0, 0, 16'hFFFF);
    check("wrap_rev", 32'(wave_out), 32'hEFFF);
    check("wrap_sync", 32'(sync_out), 32'd1);
    check("wrap_busy", 32'(cfg_busy), 32'd0);
    do_reset();

    // Regular 0x1000_0000 step, then with 50% bubbles
    ph = '0;
    for (int i = 0; i < 40; i++) begin
      step(ph, 1, 0, 0, 0, 16'hFFFF);
      ph = ph + 32'h1000_0000;
    end
    check("period_16", 32'(period_len), 32'd16);
    for (int i = 0; i < 80; i++) begin
      v = i[0];
      step(ph, v, 0, 0, 0, 16'hFFFF);
      if (v) ph = ph + 32'h1000_0000;
    end
    check("period_16_bubbles", 32'(period_len), 32'd16);

    // Saturation: 256 samples per wrap exceeds the counter range
    for (int i = 0; i < 300; i++) begin
      step(ph, 1, 0, 0, 0, 16'hFFFF);
      ph = ph + 32'h0100_0000;
    end
    check("period_sat", 32'(period_len), 32'(PER_MAX));

    // Randomized traffic including reserved forms and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) ph = $urandom;
      else ph = ph + ($urandom_range(1, 64) << 22);
      step(ph, v, ld, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 65535)));
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
